// File: rtl/reg_access_ctrl.sv
// Register-file access initiator: one rf access per request, response on a valid/ready channel.
// Optional write read-back check is compiled in with `define REG_ACCESS_VERIFY_EN.
module reg_access_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [WIDTH-1:0]  resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              rf_en,
  output logic              rf_r_or_w,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [WIDTH-1:0]  rf_wdata,
  input  logic [WIDTH-1:0]  rf_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, VERIFY, RESP} state_t;

  state_t state;

  // The rf_* registers double as the latched request, so rf_wdata is also the verify reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      rf_en      <= 1'b0;
      rf_r_or_w  <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= ACCESS;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            rf_en     <= 1'b1;
            rf_r_or_w <= req_write;
            rf_addr   <= req_addr;
            rf_wdata  <= req_wdata;
          end
        end
        ACCESS: begin
          resp_write <= rf_r_or_w;
          resp_err   <= 1'b0;
          if (rf_r_or_w) begin
            resp_rdata <= '0;
`ifdef REG_ACCESS_VERIFY_EN
            state      <= VERIFY;
            rf_r_or_w  <= 1'b0;
`else
            state      <= RESP;
            rf_en      <= 1'b0;
            resp_valid <= 1'b1;
`endif
          end else begin
            resp_rdata <= rf_rdata;
            state      <= RESP;
            rf_en      <= 1'b0;
            resp_valid <= 1'b1;
          end
        end
`ifdef REG_ACCESS_VERIFY_EN
        VERIFY: begin
          resp_rdata <= rf_rdata;
          resp_err   <= (rf_rdata != rf_wdata);
          state      <= RESP;
          rf_en      <= 1'b0;
          resp_valid <= 1'b1;
        end
`endif
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          rf_en      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Randomized self-checking bench for reg_access_ctrl with a simple register-file device model.
// Define REG_ACCESS_VERIFY_EN to exercise the write read-back check.
module tb_reg_access_ctrl;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;
  localparam int NREG   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [WIDTH-1:0]  req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic              resp_write;
  logic [WIDTH-1:0]  resp_rdata;
  logic              resp_err;
  logic              busy;
  logic              rf_en;
  logic              rf_r_or_w;
  logic [ADDR_W-1:0] rf_addr;
  logic [WIDTH-1:0]  rf_wdata;
  wire  [WIDTH-1:0]  rf_rdata;

  logic [WIDTH-1:0]  rf_mem  [NREG];
  logic [WIDTH-1:0]  exp_mem [NREG];
  logic              rf_init = 1'b1;
  logic              corrupt = 1'b0;
  int                n_chk = 0;
  int                n_pass = 0;

  reg_access_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .rf_en(rf_en), .rf_r_or_w(rf_r_or_w), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  // Register-file device: drives the bus only during an enabled read, else floats.
  assign rf_rdata = (rf_en && !rf_r_or_w) ? rf_mem[rf_addr] : 'z;

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < NREG; i++) rf_mem[i] <= WIDTH'(16'hA000 + i);
    end else if (rf_en && rf_r_or_w) begin
      rf_mem[rf_addr] <= rf_wdata | WIDTH'(corrupt);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic wr, input logic [ADDR_W-1:0] addr,
                     input logic [WIDTH-1:0] data, input int hold);
    logic [WIDTH-1:0] exp_rd;
    logic [WIDTH-1:0] stored;
    logic             exp_err;
    int               exp_lat, lat, en_cyc, n;
    exp_err = 1'b0;
    exp_lat = 2;
    if (wr) begin
      stored = data | WIDTH'(corrupt);
`ifdef REG_ACCESS_VERIFY_EN
      exp_rd  = stored;
      exp_err = (stored != data);
      exp_lat = 3;
`else
      exp_rd  = '0;
`endif
      exp_mem[addr] = stored;
    end else begin
      exp_rd = exp_mem[addr];
    end

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
    n = 0;
    while (!req_ready && n < 20) begin tick; n++; end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = ADDR_W'($urandom_range(0, NREG - 1));
    req_wdata = WIDTH'($urandom);
    chk("acc_rf_en", 32'(rf_en), 32'd1);
    chk("acc_addr", 32'(rf_addr), 32'(addr));
    chk("acc_rw", 32'(rf_r_or_w), 32'(wr));
    chk("acc_wdata", 32'(rf_wdata), 32'(data));
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_req_ready", 32'(req_ready), 32'd0);

    lat = 1;
    en_cyc = rf_en ? 1 : 0;
    while (!resp_valid && lat < 10) begin
      tick;
      lat++;
      if (!resp_valid && rf_en) en_cyc++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rf_en_cycles", 32'(en_cyc), 32'(exp_lat - 1));
    chk("resp_rdata", 32'(resp_rdata), 32'(exp_rd));
    chk("resp_write", 32'(resp_write), 32'(wr));
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chk("resp_rf_en", 32'(rf_en), 32'd0);
    chk("resp_busy", 32'(busy), 32'd1);
    chk("resp_xz", 32'($isunknown(resp_rdata)), 32'd0);

    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      tick;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", 32'(resp_rdata), 32'(exp_rd));
      chk("hold_write", 32'(resp_write), 32'(wr));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_rf_en", 32'(rf_en), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("done_valid", 32'(resp_valid), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_rf_en", 32'(rf_en), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREG; i++) exp_mem[i] = WIDTH'(16'hA000 + i);
    repeat (3) tick;
    rst = 1'b0;
    rf_init = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rf_en", 32'(rf_en), 32'd0);
    chk("rst_rf_rw", 32'(rf_r_or_w), 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_resp_write", 32'(resp_write), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);

    // Reset in the middle of an access: the write must be dropped and no response appear.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd5; req_wdata = 16'hDEAD;
    tick;
    req_valid = 1'b0;
    chk("mid_rf_en_before", 32'(rf_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rf_en", 32'(rf_en), 32'd0);
    chk("mid_req_ready", 32'(req_ready), 32'd1);
    chk("mid_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_rst_rf_en", 32'(rf_en), 32'd0);
    end
    txn(1'b0, 4'd5, 16'h0, 0);

    txn(1'b1, 4'd3, 16'hBEEF, 0);
    txn(1'b0, 4'd3, 16'h0, 0);

    for (int i = 0; i < NREG; i++) txn(1'b1, ADDR_W'(i), WIDTH'(16'h1000 + i), 0);
    for (int i = NREG - 1; i >= 0; i--) txn(1'b0, ADDR_W'(i), 16'h0, 0);

    txn(1'b1, 4'd7, 16'h1234, 5);
    txn(1'b0, 4'd7, 16'h0, 5);

    repeat (150) begin
      txn(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NREG - 1)),
          WIDTH'($urandom), $urandom_range(0, 3));
    end

`ifdef REG_ACCESS_VERIFY_EN
    corrupt = 1'b1;
    txn(1'b1, 4'd9, 16'h0000, 0);
    corrupt = 1'b0;
    txn(1'b1, 4'd10, 16'h55AA, 0);
    txn(1'b0, 4'd9, 16'h0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
